// File: rtl/trainer_pkg.sv
// Shared constants for the gate trainer: gate op codes, FSM state encoding
// and the default MISR polynomial.
package trainer_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_BUF  = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [15:0] POLY_DEFAULT = 16'h1021;

endpackage

// File: rtl/trainer_gate_alu.sv
// Combinational WIDTH-bit bitwise gate; every op code has a defined function.
module trainer_gate_alu
  import trainer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_NOT:  y_o = ~a_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_BUF:  y_o = a_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_trainer_sweep.sv
// Gate trainer with registered manual path and a self-driven operand sweep
// whose results are compacted into a MISR signature.
module logic_trainer_sweep
  import trainer_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [WIDTH-1:0] cur_a,
  output logic [WIDTH-1:0] cur_b
);

  localparam int              CNT_W    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d, ca_q, ca_d, cb_q, cb_d;
  logic             yv_q, yv_d;

  logic             in_sweep;
  logic [WIDTH-1:0] sa, sb, alu_a, alu_b, alu_y;
  logic [2:0]       alu_op;

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : '0;
    return (s << 1) ^ fb ^ SIG_W'(d);
  endfunction

  assign in_sweep = (state_q == ST_SWEEP);
  assign sa       = cnt_q[WIDTH-1:0];
  assign sb       = cnt_q[CNT_W-1:WIDTH];

  // One shared gate: the sweep operands replace the manual inputs while sweeping.
  assign alu_op = in_sweep ? op_q : op;
  assign alu_a  = in_sweep ? sa   : a;
  assign alu_b  = in_sweep ? sb   : b;

  trainer_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    op_d    = op_q;
    y_d     = y_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    yv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode) begin
          if (start && en) begin
            state_d = ST_SWEEP;
            cnt_d   = '0;
            sig_d   = '0;
            op_d    = op;
          end
        end else if (en) begin
          y_d  = alu_y;
          ca_d = a;
          cb_d = b;
          yv_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (!mode) begin
          state_d = ST_IDLE;
        end else if (en) begin
          y_d   = alu_y;
          ca_d  = sa;
          cb_d  = sb;
          yv_d  = 1'b1;
          sig_d = misr_next(sig_q, alu_y);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!mode) begin
          state_d = ST_IDLE;
        end else if (start && en) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
          sig_d   = '0;
          op_d    = op;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      op_q    <= '0;
      y_q     <= '0;
      ca_q    <= '0;
      cb_q    <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      op_q    <= op_d;
      y_q     <= y_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      yv_q    <= yv_d;
    end
  end

  assign y       = y_q;
  assign y_valid = yv_q;
  assign cur_a   = ca_q;
  assign cur_b   = cb_q;
  assign sig     = sig_q;
  assign busy    = (state_q == ST_SWEEP);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_logic_trainer_sweep.sv
// Directed bench: WIDTH=4 manual gates, WIDTH=1 sweeps with pause/relaunch,
// WIDTH=2 abort and mid-sweep reset.
module tb_logic_trainer_sweep;

  logic clk = 1'b0;
  logic rst, en, mode, start;
  logic [2:0] op;

  logic [3:0] a4, b4, y4, ca4, cb4;
  logic       yv4, busy4, done4;
  logic [15:0] sig4;

  logic [0:0] a1, b1, y1, ca1, cb1;
  logic       yv1, busy1, done1;
  logic [15:0] sig1;

  logic [1:0] a2, b2, y2, ca2, cb2;
  logic       yv2, busy2, done2;
  logic [15:0] sig2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_trainer_sweep #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .a(a4), .b(b4), .op(op), .mode(mode),
    .start(start), .y(y4), .y_valid(yv4), .busy(busy4), .done(done4),
    .sig(sig4), .cur_a(ca4), .cur_b(cb4));

  logic_trainer_sweep #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .op(op), .mode(mode),
    .start(start), .y(y1), .y_valid(yv1), .busy(busy1), .done(done1),
    .sig(sig1), .cur_a(ca1), .cur_b(cb1));

  logic_trainer_sweep #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .a(a2), .b(b2), .op(op), .mode(mode),
    .start(start), .y(y2), .y_valid(yv2), .busy(busy2), .done(done2),
    .sig(sig2), .cur_a(ca2), .cur_b(cb2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] man_exp [8];
  logic [0:0] and_exp [4];
  logic [0:0] or_exp  [4];
  logic [15:0] or_sig [4];

  initial begin
    man_exp = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b1100};
    and_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    or_exp  = '{1'b0, 1'b1, 1'b1, 1'b1};
    or_sig  = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};

    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; op = 3'b000;
    a4 = '0; b4 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    tick();
    tick();
    chk("rst_y", 32'(y4), 32'h0);
    chk("rst_yv", 32'(yv4), 32'h0);
    chk("rst_busy", 32'(busy4), 32'h0);
    chk("rst_done", 32'(done4), 32'h0);
    chk("rst_sig", 32'(sig4), 32'h0);

    // Manual gates on the 4-bit unit
    rst = 1'b0; en = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      tick();
      chk($sformatf("man_y_op%0d", i), 32'(y4), 32'(man_exp[i]));
      chk($sformatf("man_yv_op%0d", i), 32'(yv4), 32'h1);
    end
    chk("man_cur_a", 32'(ca4), 32'hc);
    chk("man_cur_b", 32'(cb4), 32'ha);
    en = 1'b0; a4 = 4'b0000; op = 3'b000;
    tick();
    chk("man_hold_y", 32'(y4), 32'hc);
    chk("man_hold_yv", 32'(yv4), 32'h0);
    chk("man_hold_sig", 32'(sig4), 32'h0);

    // AND sweep, WIDTH=1
    en = 1'b1; op = 3'b000; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("and_launch_busy", 32'(busy1), 32'h1);
    chk("and_launch_yv", 32'(yv1), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("and_y%0d", k), 32'(y1), 32'(and_exp[k]));
      chk($sformatf("and_yv%0d", k), 32'(yv1), 32'h1);
      chk($sformatf("and_busy%0d", k), 32'(busy1), (k < 3) ? 32'h1 : 32'h0);
      chk($sformatf("and_done%0d", k), 32'(done1), (k < 3) ? 32'h0 : 32'h1);
    end
    chk("and_sig", 32'(sig1), 32'h0001);

    mode = 1'b0;
    tick();
    chk("idle_done_clr", 32'(done1), 32'h0);

    // OR sweep with op change and a 3-cycle pause after step 2
    op = 3'b001; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    chk("or_launch_sig", 32'(sig1), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("or_y%0d", k), 32'(y1), 32'(or_exp[k]));
      chk($sformatf("or_sig%0d", k), 32'(sig1), 32'(or_sig[k]));
    end
    en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick();
      chk($sformatf("pause_y%0d", p), 32'(y1), 32'h1);
      chk($sformatf("pause_yv%0d", p), 32'(yv1), 32'h0);
      chk($sformatf("pause_sig%0d", p), 32'(sig1), 32'h0001);
      chk($sformatf("pause_busy%0d", p), 32'(busy1), 32'h1);
    end
    en = 1'b1;
    for (int k = 2; k < 4; k++) begin
      tick();
      chk($sformatf("or_y%0d", k), 32'(y1), 32'(or_exp[k]));
      chk($sformatf("or_sig%0d", k), 32'(sig1), 32'(or_sig[k]));
      chk($sformatf("or_done%0d", k), 32'(done1), (k < 3) ? 32'h0 : 32'h1);
    end
    chk("or_cur_a", 32'(ca1), 32'h1);
    chk("or_cur_b", 32'(cb1), 32'h1);

    // Relaunch from DONE reproduces the signature
    op = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rel_sig_clr", 32'(sig1), 32'h0);
    chk("rel_busy", 32'(busy1), 32'h1);
    chk("rel_done", 32'(done1), 32'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("rel_sig", 32'(sig1), 32'h0007);
    chk("rel_done_end", 32'(done1), 32'h1);

    // WIDTH=2 XOR sweep aborted after 4 steps
    mode = 1'b0;
    tick();
    op = 3'b101; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("ab_busy", 32'(busy2), 32'h1);
    chk("ab_y", 32'(y2), 32'h3);
    chk("ab_cur_a", 32'(ca2), 32'h3);
    chk("ab_cur_b", 32'(cb2), 32'h0);
    chk("ab_sig", 32'(sig2), 32'h0003);
    mode = 1'b0;
    tick();
    chk("ab_idle_busy", 32'(busy2), 32'h0);
    chk("ab_idle_done", 32'(done2), 32'h0);
    chk("ab_sig_keep", 32'(sig2), 32'h0003);
    a2 = 2'b10; b2 = 2'b11;
    tick();
    chk("ab_manual_y", 32'(y2), 32'h1);
    chk("ab_manual_sig", 32'(sig2), 32'h0003);

    // Reset in the middle of a sweep
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(busy2), 32'h1);
    rst = 1'b1;
    tick();
    chk("mrst_y", 32'(y2), 32'h0);
    chk("mrst_yv", 32'(yv2), 32'h0);
    chk("mrst_busy", 32'(busy2), 32'h0);
    chk("mrst_done", 32'(done2), 32'h0);
    chk("mrst_sig", 32'(sig2), 32'h0);
    chk("mrst_cur_a", 32'(ca2), 32'h0);
    chk("mrst_cur_b", 32'(cb2), 32'h0);
    rst = 1'b0; mode = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_trainer_sweep.md
# logic_trainer_sweep

Parametrised successor to the single-bit gate trainer: a WIDTH-bit bitwise gate unit with registered output, plus a self-driven sweep mode that steps through every operand combination for the selected gate. Each result is folded into a MISR signature that students compare against a known-good value. It sits behind the TinyTapeout IO wrapper, taking operands and selects from `ui_in`/`uio_in` and driving results and status onto `uo_out`.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width in bits; legal range 1..6.
- `SIG_W`, 16, signature width; must be ≥ WIDTH.
- `POLY`, 16'h1021, MISR feedback polynomial of width SIG_W.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: clock enable; when low, the manual path is held and the sweep pauses.
- `a` in WIDTH: manual operand A.
- `b` in WIDTH: manual operand B.
- `op` in 3: gate select. 000 AND, 001 OR, 010 NOT(a), 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 BUF(a).
- `mode` in 1: 0 manual, 1 sweep.
- `start` in 1: sweep launch pulse.
- `y` out WIDTH: registered result.
- `y_valid` out 1: `y` was updated at the last edge.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; signature is final.
- `sig` out SIG_W: MISR signature.
- `cur_a` out WIDTH, `cur_b` out WIDTH: operands that produced the current `y`.

## Operation
- Gate function f(op, a, b) is bitwise over WIDTH bits. All 8 codes are defined, with no default-zero case.
- FSM states:
  - IDLE. If mode=1 and start=1 and en=1, go to SWEEP. Else stay.
  - SWEEP. If mode=0, go to IDLE (abort). Else if en=1 and cnt == 2^(2·WIDTH)−1, go to DONE. Else stay.
  - DONE. If mode=0, go to IDLE. Else if start=1 and en=1, go to SWEEP. Else stay.
- Manual (IDLE, mode=0):
  - en=1: y←f(op,a,b), cur_a←a, cur_b←b, y_valid←1.
  - en=0: y, cur_a and cur_b hold; y_valid←0.
  - sig holds.
- Sweep launch (IDLE→SWEEP or DONE→SWEEP):
  - cnt←0, sig←0, op latched into op_q, y_valid←0.
  - Later changes to `op` are ignored until the next launch.
- Sweep step, each SWEEP cycle with en=1:
  - Operands: sa=cnt[WIDTH−1:0], sb=cnt[2·WIDTH−1:WIDTH].
  - y←f(op_q,sa,sb), cur_a←sa, cur_b←sb, y_valid←1.
  - sig←(sig<<1) ^ (sig[SIG_W−1] ? POLY : 0) ^ zero-extend(f(op_q,sa,sb)).
  - cnt←cnt+1, with the counter 2·WIDTH bits wide (wrap is harmless).
- Sweep pause (SWEEP, en=0): cnt, sig, y and cur_* hold; y_valid←0.
- Abort (SWEEP, mode→0): return to IDLE; sig keeps its partial value; done stays 0.
- start while in SWEEP is ignored.
- Status outputs:
  - busy = (state==SWEEP).
  - done = (state==DONE); it stays high until relaunch or mode=0.

## Timing
- Reset (synchronous): state=IDLE; y, cur_a, cur_b, sig, cnt, op_q = 0; y_valid, busy, done = 0.
- Reset mid-sweep returns everything to these values at the next edge.
- Manual latency: 1 cycle from a/b/op sample to `y`.
- Sweep of N=2^(2·WIDTH) steps:
  - start is sampled at edge E0.
  - busy is high after E0.
  - Steps occur at edges E1..EN (assuming en held high).
  - done rises after EN; sig is final at the same time.
- The edge that launches a sweep produces no y_valid.

## Structure
- Package `trainer_pkg` holds:
  - op code localparams (OP_AND … OP_BUF);
  - the FSM state encoding (ST_IDLE, ST_SWEEP, ST_DONE);
  - the default POLY.
- Sub-module `trainer_gate_alu`: a combinational WIDTH-parametrised f(op,a,b). It is instantiated once and fed by a mux that selects manual {op,a,b} or sweep {op_q,sa,sb}.
- The top level holds the FSM, counter, MISR and output registers.

## Test plan
- Manual, WIDTH=4: a=4'b1100, b=4'b1010, op cycles 000..111 with en=1. Required y one cycle later: 1000, 1110, 0011, 0111, 0001, 0110, 1001, 1100. y_valid=1 throughout.
- Sweep, WIDTH=1, SIG_W=16, op=AND: start pulse. Required:
  - busy for 4 cycles;
  - y sequence 0,0,0,1;
  - done=1 with sig=16'h0001.
- Sweep, WIDTH=1, op=OR: y sequence 0,1,1,1; final sig=16'h0007. Changing `op` mid-sweep does not alter the result.
- Pause: during the WIDTH=1 OR sweep, drop en for 3 cycles after step 2. Required:
  - cnt, sig and y hold and y_valid=0 while en is low;
  - the final sig is still 16'h0007;
  - done arrives 3 cycles late.
- Abort and reset: in a WIDTH=2 sweep, set mode=0 mid-sweep and confirm IDLE with done=0. Then launch again and assert rst mid-sweep; all outputs must be 0 at the next edge.
- Relaunch from DONE with start=1 → sig clears to 0 and the same signature is reproduced.
